btn_conditioner: RTL
====================

Name: btn_conditioner

Overview:
- Front-end stage for the serial 4-bit entry path; sits directly upstream of the bit-collector stage.
- Takes three raw, bouncing, active-low pushbuttons (start, bit-0 key, bit-1 key) and produces clean, synchronised, active-low levels `start`, `bin0`, `bin1`.
- Guarantees downstream mutual exclusion of `bin0`/`bin1`, and a released (11) gap between consecutive bits.
- Also emits one-cycle press strobes for status/LED logic.

Parameters:
- DB_CYCLES, 8: consecutive synchronised samples that must disagree with the stable level before the stable level flips (valid range 2..2^CNT_W).
- CNT_W, 4: width of each debounce counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- start_raw  input  1  raw start button, active-low, asynchronous to clk
- bin0_raw  input  1  raw bit-0 key, active-low, asynchronous
- bin1_raw  input  1  raw bit-1 key, active-low, asynchronous
- start  output  1  debounced start, active-low
- bin0  output  1  arbitrated bit-0 level, active-low (low = entering a 0)
- bin1  output  1  arbitrated bit-1 level, active-low (low = entering a 1)
- press_start  output  1  one-cycle pulse when debounced start goes low
- press_0  output  1  one-cycle pulse on entry to HOLD0
- press_1  output  1  one-cycle pulse on entry to HOLD1
- conflict  output  1  one-cycle pulse on entry to LOCK

Behaviour:

Reset (rst_n low, asynchronous):
- All synchroniser flops and stable levels = 1.
- Counters = 0; FSM = IDLE.
- start = bin0 = bin1 = 1; all pulses = 0.
- Reset asserted mid-press aborts immediately. After release, a still-held button is re-debounced from scratch (full DB_CYCLES).

Synchroniser:
- Two flops per input, reset to 1.

Debounce (per channel, identical):
- If sync2 != stable: counter increments. When counter == DB_CYCLES-1 and the mismatch persists, stable <= sync2 and counter <= 0.
- If sync2 == stable: counter <= 0. Any glitch shorter than DB_CYCLES samples is fully rejected.
- Latency: a clean raw change settled before edge 1 flips stable on edge DB_CYCLES+2.

Start path:
- start = stable_start, registered.
- press_start = 1 for exactly the cycle after stable_start falls.

Bit arbiter FSM (inputs d0 = stable_bin0, d1 = stable_bin1; state registered, outputs decoded from state):
- IDLE: bin0 = 1, bin1 = 1.
  - d0 = 0, d1 = 1 -> HOLD0
  - d1 = 0, d0 = 1 -> HOLD1
  - d0 = 0, d1 = 0 -> LOCK
- HOLD0: bin0 = 0, bin1 = 1.
  - d0 = 0 -> stay (d1 pressing meanwhile is ignored; first press wins)
  - d0 = 1, d1 = 1 -> IDLE
  - d0 = 1, d1 = 0 -> LOCK
- HOLD1: symmetric to HOLD0.
- LOCK: bin0 = 1, bin1 = 1; exits to IDLE only when d0 = 1 and d1 = 1.
- Pulses press_0, press_1, conflict are high during the first cycle in HOLD0, HOLD1, LOCK respectively.
- Latency: bin0/bin1 change one edge after the debounced change, i.e. edge DB_CYCLES+3 from a raw change.
- Invariants:
  - bin0 and bin1 are never both 0.
  - Every HOLDx exit passes through at least one cycle with bin0 = bin1 = 1 (IDLE or LOCK), so the downstream collector always sees a release between bits.
  - A HOLDx state is never followed directly by another HOLDx state.

Test Plan:
1. Reset, then bin0_raw low for 40 cycles -> bin0 falls on edge 11 (DB_CYCLES = 8), press_0 high for exactly 1 cycle, bin1 = 1 throughout. Release -> bin0 back to 1 at edge 11 after release.
2. bin1_raw bounces 5 times with 3-cycle pulses, then holds low -> no output activity during bouncing; bin1 falls 11 edges after the final settle; exactly one press_1.
3. bin0_raw and bin1_raw driven low on the same cycle -> conflict pulse once, bin0 = bin1 = 1. Release bin0 only -> still 11. Release both -> IDLE. Then press bin1 -> HOLD1, bin1 = 0.
4. Hold bin0 (HOLD0), then press bin1 -> stay HOLD0. Release bin0 while bin1 is held -> LOCK, conflict pulse, bin1 stays 1. Release bin1 -> IDLE.
5. Enter the sequence 0,1,1,0 with 20-cycle gaps -> exactly 4 press pulses in order press_0, press_1, press_1, press_0, with a 11 gap ≥ 1 cycle between each pair of bits. start_raw low for 30 cycles -> start falls at edge 10, press_start pulses once.
6. Assert rst_n mid-HOLD1 while bin1_raw remains held -> outputs return to 1 immediately. After rst_n release, bin1 falls again only after a full 11 edges.

Source files
------------

// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
//   Front end of the serial 4-bit entry path. Synchronises and debounces three
//   raw active-low pushbuttons. The two bit keys then go through an arbiter
//   that makes bin0/bin1 mutually exclusive and forces a released (11) gap
//   between consecutive bits.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start_raw    raw start button, active-low, asynchronous to clk
//   bin0_raw     raw bit-0 key, active-low, asynchronous
//   bin1_raw     raw bit-1 key, active-low, asynchronous
//   start        debounced start level, active-low
//   bin0         arbitrated bit-0 level, active-low
//   bin1         arbitrated bit-1 level, active-low
//   press_start  one-cycle pulse when debounced start falls
//   press_0      one-cycle pulse on entry to HOLD0
//   press_1      one-cycle pulse on entry to HOLD1
//   conflict     one-cycle pulse on entry to LOCK
//
// Arbiter states
//   state | meaning
//   IDLE  | no bit key held, bin0 = bin1 = 1
//   HOLD0 | bit-0 key owns the path, bin0 = 0 (a later bit-1 press is ignored)
//   HOLD1 | bit-1 key owns the path, bin1 = 0 (a later bit-0 press is ignored)
//   LOCK  | ambiguous press, bin0 = bin1 = 1 until both keys are released
// ---------------------------------------------------------------------------
module btn_conditioner #(
  parameter int DB_CYCLES = 8,
  parameter int CNT_W     = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_raw,
  input  logic bin0_raw,
  input  logic bin1_raw,
  output logic start,
  output logic bin0,
  output logic bin1,
  output logic press_start,
  output logic press_0,
  output logic press_1,
  output logic conflict
);

  // Channel index: 0 = start, 1 = bin0, 2 = bin1
  localparam int NCH = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD0 = 2'd1,
    S_HOLD1 = 2'd2,
    S_LOCK  = 2'd3
  } state_t;

  logic [NCH-1:0]   sync1_q, sync1_d;
  logic [NCH-1:0]   sync2_q, sync2_d;
  logic [NCH-1:0]   stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic             press_start_q, press_start_d;

  state_t state_q, state_d;
  logic   bin0_q, bin0_d;
  logic   bin1_q, bin1_d;
  logic   press_0_q, press_0_d;
  logic   press_1_q, press_1_d;
  logic   conflict_q, conflict_d;

  logic d0, d1;

  // -------------------------------------------------------------------------
  // Synchroniser and debounce
  // -------------------------------------------------------------------------
  always_comb begin
    sync1_d  = {bin1_raw, bin0_raw, start_raw};
    sync2_d  = sync1_q;
    stable_d = stable_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        // Flip only after DB_CYCLES consecutive disagreeing samples; any
        // agreeing sample restarts the count from zero.
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    press_start_d = stable_q[0] & ~stable_d[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= '1;
      sync2_q       <= '1;
      stable_q      <= '1;
      press_start_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      stable_q      <= stable_d;
      press_start_q <= press_start_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Bit arbiter
  // -------------------------------------------------------------------------
  assign d0 = stable_q[1];
  assign d1 = stable_q[2];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!d0 && !d1)     state_d = S_LOCK;
        else if (!d0)       state_d = S_HOLD0;
        else if (!d1)       state_d = S_HOLD1;
      end
      S_HOLD0: begin
        if (d0) state_d = d1 ? S_IDLE : S_LOCK;
      end
      S_HOLD1: begin
        if (d1) state_d = d0 ? S_IDLE : S_LOCK;
      end
      S_LOCK: begin
        if (d0 && d1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    bin0_d     = (state_d != S_HOLD0);
    bin1_d     = (state_d != S_HOLD1);
    press_0_d  = (state_d == S_HOLD0) && (state_q != S_HOLD0);
    press_1_d  = (state_d == S_HOLD1) && (state_q != S_HOLD1);
    conflict_d = (state_d == S_LOCK)  && (state_q != S_LOCK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bin0_q     <= 1'b1;
      bin1_q     <= 1'b1;
      press_0_q  <= 1'b0;
      press_1_q  <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin0_q     <= bin0_d;
      bin1_q     <= bin1_d;
      press_0_q  <= press_0_d;
      press_1_q  <= press_1_d;
      conflict_q <= conflict_d;
    end
  end

  assign start       = stable_q[0];
  assign press_start = press_start_q;
  assign bin0        = bin0_q;
  assign bin1        = bin1_q;
  assign press_0     = press_0_q;
  assign press_1     = press_1_q;
  assign conflict    = conflict_q;

endmodule
